// File: rtl/alu_rf_reader.sv
// alu_rf_reader: sweeps register-file address pairs (k, k+1 mod NUM_REGS)
// through an external combinational ALU and hands each result out over a
// valid/ready port. Optional XOR checksum of transferred results is built
// only when the macro ALU_RF_READER_CHECKSUM_EN is defined; otherwise the
// checksum output is tied to zero.
//
// Handshake: res_valid rises when a result is captured. While it is high,
// res_data and res_addr are frozen. A transfer happens on a rising clk edge
// where res_valid and res_ready are both high, and res_valid drops on that
// same edge. res_ready has no effect while res_valid is low.
`timescale 1ns/1ps

module alu_rf_reader #(
  parameter int NUM_REGS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_sel,
  input  logic       carry_sel,
  output logic [2:0] Read_Addr_1,
  output logic [2:0] Read_Addr_2,
  output logic [2:0] opcode,
  output logic       c_in,
  input  logic [8:0] alu_out,
  output logic [8:0] res_data,
  output logic [2:0] res_addr,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic       done,
  output logic [8:0] checksum,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  // Index of the final pair; that pair wraps its second address to 0.
  localparam logic [2:0] LAST_K = 3'(NUM_REGS - 1);

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [2:0] ra1_q, ra1_d;
  logic [2:0] ra2_q, ra2_d;
  logic [2:0] opcode_q, opcode_d;
  logic       c_in_q, c_in_d;
  logic [8:0] res_data_q, res_data_d;
  logic [2:0] res_addr_q, res_addr_d;
  logic       res_valid_q, res_valid_d;

  logic       accept_start;
  logic       xfer;

  // Successor address modulo NUM_REGS.
  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == LAST_K) ? 3'd0 : v + 3'd1;
  endfunction

  assign accept_start = (state_q == IDLE) && start;
  assign xfer         = (state_q == HOLD) && res_ready;

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ra1_d       = ra1_q;
    ra2_d       = ra2_q;
    opcode_d    = opcode_q;
    c_in_d      = c_in_q;
    res_data_d  = res_data_q;
    res_addr_d  = res_addr_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opcode_d = op_sel;
          c_in_d   = carry_sel;
          k_d      = 3'd0;
          // Addresses are loaded here so they are already stable in ISSUE.
          ra1_d    = 3'd0;
          ra2_d    = wrap_inc(3'd0);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Settle cycle: the ALU sees stable addresses for a full cycle.
        state_d = CAPTURE;
      end
      CAPTURE: begin
        res_data_d  = alu_out;
        res_addr_d  = k_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (k_q == LAST_K) begin
            state_d = FINISH;
          end else begin
            k_d     = k_q + 3'd1;
            ra1_d   = k_q + 3'd1;
            ra2_d   = wrap_inc(k_q + 3'd1);
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      ra1_q       <= 3'd0;
      ra2_q       <= 3'd0;
      opcode_q    <= 3'd0;
      c_in_q      <= 1'b0;
      res_data_q  <= 9'd0;
      res_addr_q  <= 3'd0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ra1_q       <= ra1_d;
      ra2_q       <= ra2_d;
      opcode_q    <= opcode_d;
      c_in_q      <= c_in_d;
      res_data_q  <= res_data_d;
      res_addr_q  <= res_addr_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef ALU_RF_READER_CHECKSUM_EN
  logic [8:0] checksum_q, checksum_d;

  // Checksum clears on an accepted start and folds in each transferred result.
  always_comb begin
    checksum_d = checksum_q;
    if (accept_start) begin
      checksum_d = 9'd0;
    end else if (xfer) begin
      checksum_d = checksum_q ^ res_data_q;
    end
  end

  // Checksum register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= 9'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 9'd0;
`endif

  assign Read_Addr_1 = ra1_q;
  assign Read_Addr_2 = ra2_q;
  assign opcode      = opcode_q;
  assign c_in        = c_in_q;
  assign res_data    = res_data_q;
  assign res_addr    = res_addr_q;
  assign res_valid   = res_valid_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_rf_reader.sv
// Directed bench for alu_rf_reader with a behavioural regfile + ALU model
// and an expected-result queue.
`timescale 1ns/1ps

module tb_alu_rf_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start = 1'b0;
  logic [2:0] op_sel = 3'd0;
  logic       carry_sel = 1'b0;
  logic [2:0] Read_Addr_1, Read_Addr_2, opcode;
  logic       c_in;
  logic [8:0] alu_out;
  logic [8:0] res_data;
  logic [2:0] res_addr;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       busy, done;
  logic [8:0] checksum;
  logic [2:0] dbg_state;

  alu_rf_reader #(.NUM_REGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_sel      (op_sel),
    .carry_sel   (carry_sel),
    .Read_Addr_1 (Read_Addr_1),
    .Read_Addr_2 (Read_Addr_2),
    .opcode      (opcode),
    .c_in        (c_in),
    .alu_out     (alu_out),
    .res_data    (res_data),
    .res_addr    (res_addr),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum),
    .dbg_state_o (dbg_state)
  );

  // ---------------- regfile + ALU model ----------------
  logic [7:0] rf [8];
  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'(1 << i);
  end

  always_comb begin
    logic [7:0] a, b;
    a = rf[Read_Addr_1];
    b = rf[Read_Addr_2];
    case (opcode)
      3'd0:    alu_out = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
      3'd1:    alu_out = {1'b0, a} - {1'b0, b} - {8'd0, c_in};
      3'd2:    alu_out = {1'b0, a & b};
      3'd3:    alu_out = {1'b0, a | b};
      default: alu_out = {1'b0, a ^ b};
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];   // {addr, data}
  logic [8:0]  exp_cs = 9'd0;
  logic [2:0]  exp_op = 3'd0;
  logic        exp_cin = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          xfer_cnt = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hand formula for an add sweep over the 1,2,4,...,128 preload.
  function automatic logic [11:0] exp_entry(input int k, input logic cin);
    logic [8:0] d;
    d = 9'((1 << k) + (1 << ((k + 1) % 8)) + int'(cin));
    return {3'(k), d};
  endfunction

  task automatic load_sweep(input logic cin);
    exp_q.delete();
    exp_cs = 9'd0;
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_entry(k, cin));
  endtask

  function automatic logic [8:0] exp_checksum();
`ifdef ALU_RF_READER_CHECKSUM_EN
    return exp_cs;
`else
    return 9'd0;
`endif
  endfunction

  // Monitor: transfers, done pulses and captured opcode/c_in.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        check("opcode_held", 16'(opcode), 16'(exp_op));
        check("c_in_held", 16'(c_in), 16'(exp_cin));
      end
      if (done) done_cnt++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_result: got addr %0d data %0d expected none", res_addr, res_data);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("res_data", 16'(res_data), 16'(e[8:0]));
          check("res_addr", 16'(res_addr), 16'(e[11:9]));
          exp_cs ^= e[8:0];
          xfer_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [2:0] op, input logic cin);
    op_sel    = op;
    carry_sel = cin;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ra1"}, 16'(Read_Addr_1), 16'd0);
    check({tag, "_ra2"}, 16'(Read_Addr_2), 16'd0);
    check({tag, "_opcode"}, 16'(opcode), 16'd0);
    check({tag, "_c_in"}, 16'(c_in), 16'd0);
    check({tag, "_res_data"}, 16'(res_data), 16'd0);
    check({tag, "_res_addr"}, 16'(res_addr), 16'd0);
    check({tag, "_res_valid"}, 16'(res_valid), 16'd0);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    check({tag, "_done"}, 16'(done), 16'd0);
    check({tag, "_checksum"}, 16'(checksum), 16'd0);
  endtask

  // Wait for the done pulse (bounded), then confirm return to idle.
  task automatic wait_done(input string tag);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    check({tag, "_done_seen"}, 16'(seen), 16'd1);
    @(negedge clk);
    check({tag, "_idle_busy"}, 16'(busy), 16'd0);
    check({tag, "_idle_done"}, 16'(done), 16'd0);
  endtask

  // With res_ready parked low: wait for a result, hold it `stall` cycles
  // checking it stays put, then accept it for exactly one edge.
  task automatic serve(input int stall, input string tag);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, 16'(res_valid), 16'd1);
    if (res_valid && exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q[0];
      for (int i = 0; i < stall; i++) begin
        if (i > 0) @(negedge clk);
        check({tag, "_stall_valid"}, 16'(res_valid), 16'd1);
        check({tag, "_stall_data"}, 16'(res_data), 16'(e[8:0]));
        check({tag, "_stall_addr"}, 16'(res_addr), 16'(e[11:9]));
        check({tag, "_stall_ra1"}, 16'(Read_Addr_1), 16'(e[11:9]));
        check({tag, "_stall_ra2"}, 16'(Read_Addr_2), 16'((int'(e[11:9]) + 1) % 8));
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, x0;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Add sweep, carry 0, ready high: latency and result sequence.
    res_ready = 1'b1;
    load_sweep(1'b0);
    exp_op = 3'd0; exp_cin = 1'b0;
    d0 = done_cnt; x0 = xfer_cnt;
    @(posedge clk); #1;
    pulse_start(3'd0, 1'b0);
    @(negedge clk);  // ISSUE
    check("issue_busy", 16'(busy), 16'd1);
    check("issue_valid", 16'(res_valid), 16'd0);
    check("issue_ra1", 16'(Read_Addr_1), 16'd0);
    check("issue_ra2", 16'(Read_Addr_2), 16'd1);
    @(negedge clk);  // CAPTURE
    check("capture_valid", 16'(res_valid), 16'd0);
    @(negedge clk);  // HOLD, first result
    check("first_valid", 16'(res_valid), 16'd1);
    check("first_data", 16'(res_data), 16'd3);
    wait_done("add_c0");
    check("add_c0_count", 16'(xfer_cnt - x0), 16'd8);
    check("add_c0_done_once", 16'(done_cnt - d0), 16'd1);
    check("add_c0_queue_empty", 16'(exp_q.size()), 16'd0);
    check("add_c0_checksum", 16'(checksum), 16'(exp_checksum()));
    check("add_c0_checksum_held_last", 16'(res_data), 16'd129);

    // Add sweep, carry 1.
    load_sweep(1'b1);
    exp_op = 3'd0; exp_cin = 1'b1;
    x0 = xfer_cnt;
    pulse_start(3'd0, 1'b1);
    @(negedge clk);
    check("c1_c_in", 16'(c_in), 16'd1);
    @(negedge clk);
    @(negedge clk);
    check("c1_first_data", 16'(res_data), 16'd4);
    wait_done("add_c1");
    check("c1_count", 16'(xfer_cnt - x0), 16'd8);
    check("c1_last_data", 16'(res_data), 16'd130);
    check("c1_checksum", 16'(checksum), 16'(exp_checksum()));

    // Back-pressure: 5-cycle stall at k=2.
    res_ready = 1'b0;
    load_sweep(1'b0);
    exp_op = 3'd0; exp_cin = 1'b0;
    x0 = xfer_cnt; d0 = done_cnt;
    pulse_start(3'd0, 1'b0);
    for (int k = 0; k < 8; k++) serve((k == 2) ? 5 : 0, "bp");
    wait_done("bp");
    check("bp_count", 16'(xfer_cnt - x0), 16'd8);
    check("bp_done_once", 16'(done_cnt - d0), 16'd1);

    // Start pulsed mid-sweep must be ignored.
    res_ready = 1'b1;
    load_sweep(1'b0);
    exp_op = 3'd0; exp_cin = 1'b0;
    x0 = xfer_cnt; d0 = done_cnt;
    pulse_start(3'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(3'd5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(3'd2, 1'b1);
    wait_done("busy_start");
    check("busy_start_count", 16'(xfer_cnt - x0), 16'd8);
    check("busy_start_done_once", 16'(done_cnt - d0), 16'd1);
    check("busy_start_queue_empty", 16'(exp_q.size()), 16'd0);

    // Reset during HOLD at k=4.
    res_ready = 1'b0;
    load_sweep(1'b0);
    exp_op = 3'd0; exp_cin = 1'b0;
    pulse_start(3'd0, 1'b0);
    for (int k = 0; k < 4; k++) serve(0, "rst_pre");
    begin
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("rst_k4_valid", 16'(res_valid), 16'd1);
      check("rst_k4_addr", 16'(res_addr), 16'd4);
    end
    d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    check("midrst_no_done", 16'(done_cnt - d0), 16'd0);

    // Fresh sweep after reset starts again at k=0.
    res_ready = 1'b1;
    load_sweep(1'b0);
    x0 = xfer_cnt;
    pulse_start(3'd0, 1'b0);
    @(negedge clk);
    check("restart_ra1", 16'(Read_Addr_1), 16'd0);
    wait_done("restart");
    check("restart_count", 16'(xfer_cnt - x0), 16'd8);
    check("restart_checksum", 16'(checksum), 16'(exp_checksum()));

    // res_ready high while idle changes nothing.
    repeat (3) @(negedge clk);
    check("idle_valid", 16'(res_valid), 16'd0);
    check("idle_busy", 16'(busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_rf_reader.md
ALU_RF_READER -- requirements
Module: alu_rf_reader

Interface
REQ-001 Parameter NUM_REGS, default 8, number of register-file entries swept; address width is fixed at 3 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-005 op_sel  input  3  ALU opcode for the sweep, encoding add=0..exnor=7; captured on accepted start.
REQ-006 carry_sel  input  1  ALU carry-in for the sweep; captured on accepted start.
REQ-007 Read_Addr_1, Read_Addr_2  output  3 each  register-file read addresses driven to the ALU/register-file block.
REQ-008 opcode, c_in  output  3, 1  registered copies of op_sel and carry_sel presented to the ALU.
REQ-009 alu_out  input  9  combinational ALU result for the current read addresses.
REQ-010 res_data, res_addr  output  9, 3  captured result and the Read_Addr_1 value that produced it.
REQ-011 res_valid / res_ready  output / input  1 each  result handshake; transfer when both high on a rising edge.
REQ-012 busy, done  output  1 each  sweep in progress; one-cycle end-of-sweep pulse.
REQ-013 checksum  output  9  XOR of all results transferred in the last sweep (see Configuration).

Function
REQ-014 FSM states: IDLE, ISSUE, CAPTURE, HOLD, FINISH.
REQ-015 IDLE: start=1 -> latch op_sel/carry_sel, index k=0, clear checksum, go ISSUE; start ignored in any other state.
REQ-016 ISSUE: drive Read_Addr_1=k, Read_Addr_2=(k+1) mod NUM_REGS; go CAPTURE next cycle (one settle cycle).
REQ-017 CAPTURE: register res_data=alu_out, res_addr=k, assert res_valid, go HOLD.
REQ-018 HOLD: res_data/res_addr/res_valid stable while res_ready=0; on transfer deassert res_valid; if k=NUM_REGS-1 go FINISH else k=k+1, go ISSUE.
REQ-019 Read addresses stay constant from ISSUE through HOLD of the same k.
REQ-020 Throughput with res_ready tied high: one result per 3 cycles; first res_valid 2 cycles after start accepted.
REQ-021 Last pair wraps: k=NUM_REGS-1 reads (NUM_REGS-1, 0).
REQ-022 FINISH: pulse done for exactly one cycle, return IDLE; checksum held until next accepted start.
REQ-023 busy=1 in ISSUE, CAPTURE, HOLD, FINISH; 0 in IDLE.
REQ-024 res_ready high outside HOLD has no effect; alu_out is sampled only in CAPTURE.

Reset
REQ-025 rst=1 on a rising edge forces IDLE from any state, including mid-sweep with res_valid high; pending result discarded.
REQ-026 Reset values: Read_Addr_1=Read_Addr_2=0, opcode=0, c_in=0, res_data=0, res_addr=0, res_valid=0, busy=0, done=0, checksum=0.

Configuration
REQ-027 Macro ALU_RF_READER_CHECKSUM_EN: defined -> checksum XOR-accumulates res_data on each transfer; undefined -> accumulator not built, checksum tied to 0.

Verification
REQ-028 Regfile preloaded 1,2,4,...,128; op_sel=add, carry_sel=0, res_ready=1, start -> results 3,6,12,24,48,96,192,129 at res_addr 0..7; done once; checksum=0 (with macro).
REQ-029 Same load, op_sel=add, carry_sel=1 -> first result 4, last result 130; opcode=0, c_in=1 driven throughout.
REQ-030 res_ready held 0 for 5 cycles at k=2 -> res_valid, res_data=12, res_addr=2 stable 5 cycles; no address change; sweep completes normally.
REQ-031 start pulsed while busy -> ignored, sequence and count of 8 results unchanged.
REQ-032 rst asserted during HOLD at k=4 -> next cycle all outputs at reset values, busy=0; new start restarts at k=0.
REQ-033 Build without macro, repeat REQ-028 -> identical results, checksum=0 always.
